fft4_bfly_seq: RTL
==================

// Module: fft4_bfly_seq
// PURPOSE
//  Frame sequencer for a 4-point radix-2 DIT FFT built on one shared combinational butterfly.
//  Per frame: accepts 4 complex samples, runs 4 butterfly ops (2 stages x 2), emits 4 bins.
//  Sits between the sample stream and the butterfly unit; owns the sample buffer and the twiddle select.
//  Complex word packing: {im[WIDTH-1:WIDTH/2], re[WIDTH/2-1:0]}, both halves signed Q1.(WIDTH/2-1).
// PARAMETERS
//  WIDTH   32   complex word width; real and imag halves are WIDTH/2 bits each
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input sample valid
//  in_ready   out  1      input sample accepted when in_valid & in_ready
//  in_data    in   WIDTH  input sample x[n], n = beat index 0..3
//  out_valid  out  1      output bin valid
//  out_ready  in   1      output bin consumed when out_valid & out_ready
//  out_data   out  WIDTH  output bin X[k], k = beat index 0..3
//  out_last   out  1      high with X[3]
//  busy       out  1      high in any state other than LOAD with count 0
//  bf_a       out  WIDTH  butterfly operand A
//  bf_b       out  WIDTH  butterfly operand B
//  bf_w       out  WIDTH  butterfly twiddle W
//  bf_p       in   WIDTH  butterfly result A+WB (combinational from bf_a/b/w)
//  bf_n       in   WIDTH  butterfly result A-WB
// BEHAVIOUR
//  Reset (async, rst_n=0): state=LOAD, count=0, in_ready=0 during reset and 1 from the first clock after release;
//   out_valid=0, out_last=0, busy=0, out_data=0, bf_a/bf_b/bf_w=0. Buffer contents undefined. Mid-frame reset aborts the frame.
//  States: LOAD -> S1A -> S1B -> S2A -> S2B -> UNLOAD -> LOAD.
//  LOAD: in_ready=1; each handshake writes buf[count], count++; the 4th handshake (count=3) clears count and goes to S1A.
//  S1A: A=buf0, B=buf2, W=W0; at edge buf0<=bf_p, buf2<=bf_n.
//  S1B: A=buf1, B=buf3, W=W0; at edge buf1<=bf_p, buf3<=bf_n.
//  S2A: A=buf0, B=buf1, W=W0; at edge buf0<=bf_p (X0), buf1<=bf_n (X2).
//  S2B: A=buf2, B=buf3, W=W1; at edge buf2<=bf_p (X1), buf3<=bf_n (X3).
//  bf_* driven only in S1A..S2B; 0 in all other states. One butterfly per cycle; no stalls during compute.
//  Twiddles: W0 = {16'sh0000, 16'sh7FFF} (+1); W1 = {16'sh8001, 16'sh0000} (-j). Halves scale to WIDTH/2.
//  UNLOAD: out_valid=1, out_data order X0, X1, X2, X3 = buf0, buf2, buf1, buf3; out_last with X3.
//   out_data/out_last held stable while out_valid & !out_ready. After the X3 handshake, the next cycle is LOAD.
//  Latency: out_valid rises exactly 5 clocks after the edge accepting x[3]; in_ready=0 from that edge until LOAD.
//  No input/output overlap: in_ready=0 in all non-LOAD states; in_valid there is ignored.
//  Butterfly arithmetic and truncation are the butterfly's concern; the sequencer stores bf_p/bf_n unmodified.
//  in_valid dropping mid-frame in LOAD: count holds and no timeout applies.
// CONFIGURATION
//  FFT4_BFLY_SEQ_INV_EN defined: adds input port inv (1 bit), sampled at the x[0] handshake and held for the frame;
//   inv=1 selects W1 = {16'sh7FFF, 16'sh0000} (+j, inverse FFT, unscaled); inv=0 is identical to the forward FFT.
//  Not defined: no inv port; W1 is always -j.
// TESTING
//  Bench model of the butterfly: WB = W*B (full-width signed), keep product bits [WIDTH-2:WIDTH/2-1], then A+/-WB.
//  T1 impulse: x=[1000,0,0,0] (real) -> X0..X3 all {im 0, re 1000}; out_last only on beat 3.
//  T2 shifted: x=[0,1000,0,0] -> X0=re 999, X1=im -1000, X2=re -999, X3=im +1000; all other halves 0.
//  T3 latency/backpressure: x[3] accepted at edge t -> out_valid rises at edge t+5; out_ready=0 for 3 cycles -> out_data stays X0.
//  T4 reset mid-frame: rst_n low during S2A -> all outputs 0; new x=[1000,0,0,0] after release -> T1 result.
//  T5 back-to-back: 3 frames, in_valid tied high -> in_ready rises the cycle after each X3 handshake; every frame is correct.
//  T6 (FFT4_BFLY_SEQ_INV_EN) inv=1, x=[0,1000,0,0] -> X1=im +999, X3=im -999; X0/X2 as in T2.

Source files
------------

// File: rtl/fft4_bfly_seq_if.sv
// -----------------------------------------------------------------------------
// fft4_bfly_seq_if
// Purpose : Sample-in / bin-out stream bundle for the 4-point FFT frame
//           sequencer. Both directions use a valid/ready handshake.
// Signals : in_valid/in_ready/in_data     sample stream x[n] into the sequencer
//           out_valid/out_ready/out_data  bin stream X[k] out of the sequencer
//           out_last                      marks X[3]
// Modports: slave  - the sequencer's view (consumes samples, produces bins)
//           master - the stream driver/consumer's view
// -----------------------------------------------------------------------------
interface fft4_bfly_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/fft4_bfly_seq.sv
// -----------------------------------------------------------------------------
// fft4_bfly_seq
// Purpose : Frame sequencer for a 4-point radix-2 DIT FFT that time-shares one
//           external combinational butterfly. Per frame it loads 4 complex
//           samples, runs 4 butterflies (2 stages x 2) and unloads 4 bins in
//           order X0, X1, X2, X3.
//           Complex packing: {im[WIDTH-1:WIDTH/2], re[WIDTH/2-1:0]}, signed Q1.
// Ports   : clk, rst_n       clock (rising edge), async active-low reset
//           io (slave)       sample in / bin out stream, see fft4_bfly_seq_if
//           busy             high unless idle in LOAD with no sample taken
//           bf_a, bf_b, bf_w butterfly operands and twiddle (0 outside compute)
//           bf_p, bf_n       butterfly results A+WB, A-WB
//           inv              (only with FFT4_BFLY_SEQ_INV_EN) 1 = inverse FFT,
//                            sampled with x[0] and held for the frame
// Config  : define FFT4_BFLY_SEQ_INV_EN to add the inv port (W1 = +j when set).
// -----------------------------------------------------------------------------
module fft4_bfly_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef FFT4_BFLY_SEQ_INV_EN
    input  logic             inv,
`endif
    fft4_bfly_seq_if.slave   io,
    output logic             busy,
    output logic [WIDTH-1:0] bf_a,
    output logic [WIDTH-1:0] bf_b,
    output logic [WIDTH-1:0] bf_w,
    input  logic [WIDTH-1:0] bf_p,
    input  logic [WIDTH-1:0] bf_n
);
    localparam int HW = WIDTH / 2;
    localparam logic [HW-1:0]    Q_ZERO = {HW{1'b0}};
    localparam logic [HW-1:0]    Q_POS  = {1'b0, {(HW-1){1'b1}}};               // ~ +1
    localparam logic [HW-1:0]    Q_NEG  = {1'b1, {(HW-2){1'b0}}, 1'b1};         // ~ -1
    localparam logic [WIDTH-1:0] W0     = {Q_ZERO, Q_POS};                      // +1
    localparam logic [WIDTH-1:0] W1_FWD = {Q_NEG, Q_ZERO};                      // -j
`ifdef FFT4_BFLY_SEQ_INV_EN
    localparam logic [WIDTH-1:0] W1_INV = {Q_POS, Q_ZERO};                      // +j
`endif

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_S1A    = 3'd1,
        ST_S1B    = 3'd2,
        ST_S2A    = 3'd3,
        ST_S2B    = 3'd4,
        ST_UNLOAD = 3'd5
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [1:0]       count_r, count_nxt_s;   // load index in LOAD, bin index in UNLOAD
    logic [WIDTH-1:0] buf_r [0:3];
    logic             in_ready_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic [WIDTH-1:0] out_data_r;
    logic             busy_r;
    logic             load_hs_s;
    logic             out_hs_s;
    logic [WIDTH-1:0] w1_s;
    logic [WIDTH-1:0] bf_a_s, bf_b_s, bf_w_s;
`ifdef FFT4_BFLY_SEQ_INV_EN
    logic             inv_r;
`endif

    // Bins sit in bit-reversed slots after the second stage.
    function automatic logic [WIDTH-1:0] bin_sel(input logic [1:0] k,
                                                 input logic [WIDTH-1:0] b0,
                                                 input logic [WIDTH-1:0] b1,
                                                 input logic [WIDTH-1:0] b2,
                                                 input logic [WIDTH-1:0] b3);
        logic [WIDTH-1:0] r;
        case (k)
            2'd0:    r = b0;
            2'd1:    r = b2;
            2'd2:    r = b1;
            2'd3:    r = b3;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    assign load_hs_s    = io.in_valid & in_ready_r & (state_r == ST_LOAD);
    assign out_hs_s     = out_valid_r & io.out_ready & (state_r == ST_UNLOAD);
    assign io.in_ready  = in_ready_r;
    assign io.out_valid = out_valid_r;
    assign io.out_data  = out_data_r;
    assign io.out_last  = out_last_r;
    assign busy         = busy_r;
    assign bf_a         = bf_a_s;
    assign bf_b         = bf_b_s;
    assign bf_w         = bf_w_s;

`ifdef FFT4_BFLY_SEQ_INV_EN
    assign w1_s = inv_r ? W1_INV : W1_FWD;
`else
    assign w1_s = W1_FWD;
`endif

    // Next-state, counter and butterfly operand selection.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        bf_a_s      = {WIDTH{1'b0}};
        bf_b_s      = {WIDTH{1'b0}};
        bf_w_s      = {WIDTH{1'b0}};
        case (state_r)
            ST_LOAD: begin
                if (load_hs_s) begin
                    if (count_r == 2'd3) begin
                        count_nxt_s = 2'd0;
                        state_nxt_s = ST_S1A;
                    end else begin
                        count_nxt_s = count_r + 2'd1;
                    end
                end else begin
                    count_nxt_s = count_r;
                end
            end
            ST_S1A: begin
                bf_a_s = buf_r[0]; bf_b_s = buf_r[2]; bf_w_s = W0;
                state_nxt_s = ST_S1B;
            end
            ST_S1B: begin
                bf_a_s = buf_r[1]; bf_b_s = buf_r[3]; bf_w_s = W0;
                state_nxt_s = ST_S2A;
            end
            ST_S2A: begin
                bf_a_s = buf_r[0]; bf_b_s = buf_r[1]; bf_w_s = W0;
                state_nxt_s = ST_S2B;
            end
            ST_S2B: begin
                bf_a_s = buf_r[2]; bf_b_s = buf_r[3]; bf_w_s = w1_s;
                state_nxt_s = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                if (out_hs_s) begin
                    if (count_r == 2'd3) begin
                        count_nxt_s = 2'd0;
                        state_nxt_s = ST_LOAD;
                    end else begin
                        count_nxt_s = count_r + 2'd1;
                    end
                end else begin
                    count_nxt_s = count_r;
                end
            end
            default: begin
                state_nxt_s = ST_LOAD;
                count_nxt_s = 2'd0;
            end
        endcase
    end

    // State, handshake flags and the registered bin output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_LOAD;
            count_r     <= 2'd0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            count_r    <= count_nxt_s;
            in_ready_r <= (state_nxt_s == ST_LOAD);
            busy_r     <= !((state_nxt_s == ST_LOAD) && (count_nxt_s == 2'd0));
            if (state_r == ST_UNLOAD) begin
                if (!out_valid_r) begin
                    // First UNLOAD cycle presents X0; this adds the cycle that
                    // puts out_valid five clocks after the last sample.
                    out_valid_r <= 1'b1;
                    out_last_r  <= 1'b0;
                    out_data_r  <= bin_sel(2'd0, buf_r[0], buf_r[1], buf_r[2], buf_r[3]);
                end else if (io.out_ready) begin
                    if (count_r == 2'd3) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        out_data_r  <= {WIDTH{1'b0}};
                    end else begin
                        out_last_r  <= (count_r == 2'd2);
                        out_data_r  <= bin_sel(count_r + 2'd1, buf_r[0], buf_r[1], buf_r[2], buf_r[3]);
                    end
                end
            end else begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
                out_data_r  <= {WIDTH{1'b0}};
            end
        end
    end

`ifdef FFT4_BFLY_SEQ_INV_EN
    // Direction flag captured with x[0] so it cannot change mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_r <= 1'b0;
        end else if (load_hs_s && (count_r == 2'd0)) begin
            inv_r <= inv;
        end
    end
`endif

    // Sample buffer: loaded from the stream, then overwritten in place by each butterfly.
    always_ff @(posedge clk) begin
        case (state_r)
            ST_LOAD: begin
                if (load_hs_s) begin
                    buf_r[count_r] <= io.in_data;
                end
            end
            ST_S1A: begin buf_r[0] <= bf_p; buf_r[2] <= bf_n; end
            ST_S1B: begin buf_r[1] <= bf_p; buf_r[3] <= bf_n; end
            ST_S2A: begin buf_r[0] <= bf_p; buf_r[1] <= bf_n; end
            ST_S2B: begin buf_r[2] <= bf_p; buf_r[3] <= bf_n; end
            default: begin end
        endcase
    end
endmodule
